// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Two-stage registered bitwise gate unit. It uses valid/ready handshakes on both
// sides and supports eight selectable operations. It also produces result flags
// and a count of delivered results.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid, in_ready  input handshake (in_ready has no path from in_valid)
//   a, b, op            operands and operation select, captured on input transfer
//   out_valid, out_ready output handshake
//   y                   registered result
//   flag_zero/ones/par  flags of y: all zeros, all ones, odd parity
//   done_cnt            results delivered since reset, wraps modulo 2^CNT_W
module logic_unit_pipe #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_zero,
  output logic             flag_ones,
  output logic             flag_par,
  output logic [CNT_W-1:0] done_cnt
);

  // Bitwise operation selected by o. The results are WIDTH bits wide by
  // construction, so inverted forms carry no stray upper bits.
  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z
  );
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = x & z;
      3'b001:  r = x | z;
      3'b010:  r = x ^ z;
      3'b011:  r = ~(x & z);
      3'b100:  r = ~(x | z);
      3'b101:  r = ~(x ^ z);
      3'b110:  r = ~x;
      3'b111:  r = x;
      default: r = x;
    endcase
    return r;
  endfunction

  // Odd parity: 1 when an odd number of bits are set.
  function automatic logic odd_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [2:0]       s1_op;
  logic             s1_valid;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_xfer;
  logic             s1_move;
  logic             out_xfer;
  logic [WIDTH-1:0] res;

  // Handshake decode. It uses only registered state and out_ready, so
  // in_ready never depends on in_valid.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
    in_xfer  = in_valid && s1_adv;
    s1_move  = s1_valid && s2_adv;
    out_xfer = out_valid && out_ready;
    res      = apply_op(s1_op, s1_a, s1_b);
  end

  // Pipeline registers and delivery counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= 3'b000;
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      flag_zero <= 1'b0;
      flag_ones <= 1'b0;
      flag_par  <= 1'b0;
      done_cnt  <= '0;
    end else begin
      // S1 loads a new word on input transfer. Otherwise it empties when its
      // word moves on, so a move and a load in the same cycle leave no bubble.
      if (in_xfer) begin
        s1_a     <= a;
        s1_b     <= b;
        s1_op    <= op;
        s1_valid <= 1'b1;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end

      // S2 holds while stalled. Otherwise it takes whatever S1 offers.
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          y         <= res;
          flag_zero <= (res == {WIDTH{1'b0}});
          flag_ones <= (res == {WIDTH{1'b1}});
          flag_par  <= odd_parity(res);
        end
      end

      if (out_xfer) begin
        done_cnt <= done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe. It uses three instances:
//   dut4  WIDTH=4, CNT_W=16  main checks
//   dutw  WIDTH=4, CNT_W=3   shares dut4's inputs; checks counter wrap
//   dut1  defaults (WIDTH=1) single-bit AND checks
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] a = 4'h0;
  logic [3:0] b = 4'h0;
  logic [2:0] op = 3'b000;

  logic        in_ready, out_valid, fz, fo, fp;
  logic [3:0]  y;
  logic [15:0] cnt;

  logic        w_in_ready, w_out_valid, w_fz, w_fo, w_fp;
  logic [3:0]  w_y;
  logic [2:0]  w_cnt;

  logic        a1 = 1'b0;
  logic        b1 = 1'b0;
  logic        o1_in_ready, o1_out_valid, o1_y, o1_fz, o1_fo, o1_fp;
  logic [15:0] o1_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] sweep_exp [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111,
                                4'b0001, 4'b1001, 4'b0011, 4'b1100};

  logic_unit_pipe #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .flag_zero(fz), .flag_ones(fo), .flag_par(fp), .done_cnt(cnt)
  );

  logic_unit_pipe #(.WIDTH(4), .CNT_W(3)) dutw (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .a(a), .b(b), .op(op), .out_valid(w_out_valid), .out_ready(out_ready),
    .y(w_y), .flag_zero(w_fz), .flag_ones(w_fo), .flag_par(w_fp), .done_cnt(w_cnt)
  );

  logic_unit_pipe dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_in_ready),
    .a(a1), .b(b1), .op(op), .out_valid(o1_out_valid), .out_ready(out_ready),
    .y(o1_y), .flag_zero(o1_fz), .flag_ones(o1_fo), .flag_par(o1_fp), .done_cnt(o1_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock. Outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_y", {28'd0, y}, 32'd0);
    check_val("rst_flags", {29'd0, fz, fo, fp}, 32'd0);
    check_val("rst_cnt", {16'd0, cnt}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Send one word into an idle pipe, check the result and its flags, then let
  // it drain. out_ready is 1 throughout.
  task automatic run_one(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic [2:0] vop, input logic [3:0] ey,
                         input logic ez, input logic eo, input logic ep);
    a = va; b = vb; op = vop; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_val({tag, "_y"}, {28'd0, y}, {28'd0, ey});
    check_val({tag, "_flags"}, {29'd0, fz, fo, fp}, {29'd0, ez, eo, ep});
    tick();
  endtask

  initial begin
    tick();
    do_reset();

    // Op sweep: ops 0..7 on consecutive cycles; each y appears two edges after input.
    a = 4'b1100; b = 4'b1010;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        op = i[2:0];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check_val("sweep_y", {28'd0, y}, {28'd0, sweep_exp[i-1]});
      end else begin
        check_val("sweep_lat", {31'd0, out_valid}, 32'd0);
      end
    end
    tick();
    check_val("sweep_cnt", {16'd0, cnt}, 32'd8);
    check_val("sweep_drained", {31'd0, out_valid}, 32'd0);

    // Flags.
    run_one("fl_and0", 4'h0, 4'h0, 3'b000, 4'h0, 1'b1, 1'b0, 1'b0);
    run_one("fl_nor",  4'hF, 4'h0, 3'b100, 4'h0, 1'b1, 1'b0, 1'b0);
    run_one("fl_ones", 4'hF, 4'h3, 3'b111, 4'hF, 1'b0, 1'b1, 1'b0);
    run_one("fl_par",  4'h7, 4'h0, 3'b111, 4'h7, 1'b0, 1'b0, 1'b1);

    // Back-pressure: only two words fit while out_ready is low.
    do_reset();
    out_ready = 1'b0;
    a = 4'b1100; b = 4'b1010; op = 3'b000; in_valid = 1'b1;
    check_val("bp_rdy1", {31'd0, in_ready}, 32'd1);
    tick();
    op = 3'b001;
    check_val("bp_rdy2", {31'd0, in_ready}, 32'd1);
    tick();
    op = 3'b010;
    for (int i = 0; i < 3; i++) begin
      check_val("bp_rdy3", {31'd0, in_ready}, 32'd0);
      check_val("bp_hold_y", {28'd0, y}, 32'h8);
      check_val("bp_hold_v", {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_rdy_rel", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("bp_y2", {28'd0, y}, 32'hE);
    tick();
    check_val("bp_y3", {28'd0, y}, 32'h6);
    tick();
    check_val("bp_cnt", {16'd0, cnt}, 32'd3);
    check_val("bp_empty", {31'd0, out_valid}, 32'd0);

    // Throughput: 20 words back to back, XOR with all-ones gives ~a.
    do_reset();
    b = 4'hF; op = 3'b010;
    for (int i = 0; i < 22; i++) begin
      if (i < 20) begin
        in_valid = 1'b1;
        a = i[3:0];
        check_val("tp_rdy", {31'd0, in_ready}, 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 20) begin
        check_val("tp_valid", {31'd0, out_valid}, 32'd1);
        check_val("tp_y", {28'd0, y}, {28'd0, ~(i[3:0] - 4'd1)});
      end
    end
    check_val("tp_cnt", {16'd0, cnt}, 32'd20);
    check_val("tp_cnt_w3", {29'd0, w_cnt}, 32'd4);
    check_val("tp_empty", {31'd0, out_valid}, 32'd0);

    // Reset with both stages full, then 9 deliveries to wrap the 3-bit counter.
    out_ready = 1'b0;
    a = 4'h9; op = 3'b111; in_valid = 1'b1;
    tick();
    tick();
    check_val("mr_full_v", {31'd0, out_valid}, 32'd1);
    check_val("mr_full_rdy", {31'd0, in_ready}, 32'd0);
    do_reset();
    op = 3'b111;
    for (int i = 0; i < 11; i++) begin
      if (i < 9) begin
        in_valid = 1'b1;
        a = i[3:0] + 4'd1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1 && i <= 9) begin
        check_val("mr_y", {28'd0, y}, {28'd0, i[3:0]});
      end
    end
    check_val("wrap_cnt16", {16'd0, cnt}, 32'd9);
    check_val("wrap_cnt3", {29'd0, w_cnt}, 32'd1);

    // Default WIDTH=1 instance.
    op = 3'b000; a1 = 1'b1; b1 = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_val("w1_and11", {30'd0, o1_out_valid, o1_y}, 32'd3);
    a1 = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_val("w1_and01", {30'd0, o1_out_valid, o1_y}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered multi-function bitwise gate unit, successor to the single-function gate block. It applies one of eight selectable bitwise operations to two WIDTH-bit operands through a two-stage pipeline with valid/ready handshakes on both sides. It also produces result flags and a running transaction count. It sits between operand sources and downstream consumers in lab designs, replacing ad-hoc combinational gates wherever back-pressure or registered timing is needed.

## Interface
- WIDTH, 1, operand/result width in bits (legal 1..32)
- CNT_W, 16, width of the completed-transaction counter
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/op word presented
- in_ready  out  1  unit can accept a word this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation select, sampled with a/b on acceptance
- out_valid  out  1  result word presented
- out_ready  in  1  consumer accepts result this cycle
- y  out  WIDTH  result
- flag_zero  out  1  y == 0
- flag_ones  out  1  y == all ones
- flag_par  out  1  XOR-reduction of y (odd parity)
- done_cnt  out  CNT_W  number of results delivered since reset

## Operation
- op encoding: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a (b ignored), 111 pass a (b ignored).
- Stage 1 (S1) registers a, b, op and s1_valid on input transfer (in_valid && in_ready).
- Stage 2 (S2) computes y from the S1 registers and registers y, the three flags and s2_valid. Flags derive from the computed y, not from the operands.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from registered state and out_ready only; no path from in_valid.
- S1 → S2 moves when s1_valid && s2_adv.
- S1 empties when it moves and no new input arrives. S1 loads the new word when an input transfer occurs.
- Output transfer = out_valid && out_ready. On transfer, done_cnt increments by 1 and wraps modulo 2^CNT_W.
- Stall: while out_valid && !out_ready, y, the flags and out_valid hold stable. With both stages full, in_ready = 0.
- Simultaneous output transfer and S1 → S2 move in the same cycle: S2 takes the new word; the count still increments.
- Simultaneous input transfer and S1 → S2 move: S1 takes the new word with no bubble. Full throughput is one word per cycle.
- No word is dropped or duplicated. Results leave in acceptance order.
- Width rule: all operations are bitwise on WIDTH bits. NOT and NAND/NOR/XNOR results are masked to WIDTH, with no sign or carry bits.

## Timing
- Reset (rst = 1 at a clock edge) values:
  - s1_valid, s2_valid (out_valid) = 0.
  - y = 0, flag_zero = 0, flag_ones = 0, flag_par = 0.
  - done_cnt = 0.
  - S1 data registers = 0.
- in_ready = 1 in the first cycle after reset deasserts.
- Reset mid-operation discards all in-flight words. No output transfer is counted in the reset cycle.
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N+1, so it is presentable in cycle N+2 if S2 is free.
- in_ready during rst = 1 is don't-care. Inputs are not sampled in the reset cycle.
- done_cnt updates at the same edge as the output transfer.

## Test plan
- Op sweep, WIDTH = 4, out_ready = 1: a = 4'b1100, b = 4'b1010, op 0..7 on consecutive cycles.
  - Required y sequence: 1000, 1110, 0110, 0111, 0001, 1001, 0011, 1100.
  - Each y appears 2 cycles after its input.
  - done_cnt = 8 at the end.
- Flags, WIDTH = 4:
  - a = 0, b = 0, AND → y = 0000, flag_zero = 1, flag_ones = 0, flag_par = 0.
  - a = 4'hF, b = 4'h0, NOR → y = 0000, flag_zero = 1.
  - a = 4'hF, op 111 → y = 1111, flag_ones = 1, flag_par = 0.
  - a = 4'b0111, op 111 → flag_par = 1.
- Back-pressure:
  - Hold out_ready = 0 and stream 3 words. Only 2 are accepted; in_ready = 0 from the third cycle.
  - y stays stable on the first result.
  - Release out_ready: all 3 results emerge in order, then done_cnt = 3.
- Throughput: continuous in_valid = 1 and out_ready = 1 for 20 words gives 20 results on 20 consecutive cycles, with no bubbles.
- Reset mid-flight:
  - Assert rst with both stages full.
  - Next cycle: out_valid = 0, y = 0, done_cnt = 0, in_ready = 1.
  - The next accepted word is the first output.
- Counter wrap: CNT_W = 3 with 9 deliveries → done_cnt = 1.
- Default WIDTH = 1: a = 1, b = 1, AND → y = 1. Then a = 0, b = 1, AND → y = 0.
